// File: rtl/rc_lanes_pkg.sv
// Shared types for the multi-lane Reinforced Concrete permutation engine.
// Lane counters are sized for the largest legal lane count (16).
package rc_lanes_pkg;

    localparam int MAX_LANES      = 16;
    localparam int LANE_IDX_W     = $clog2(MAX_LANES + 1);
    localparam int DEF_N_BITS     = 254;
    localparam int DEF_STATE_SIZE = 3;
    localparam int DEF_N_LIMBS    = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } fsm_t;

    typedef logic [DEF_N_BITS-1:0] rc_state_t [DEF_STATE_SIZE][DEF_N_LIMBS];

    typedef struct packed {
        fsm_t                    state;
        logic [LANE_IDX_W-1:0]   loadCnt;
        logic [LANE_IDX_W-1:0]   drainIdx;
        logic [LANE_IDX_W-1:0]   nLanes;
        logic [MAX_LANES-1:0]    laneEn;
    } dbg_t;

endpackage

// File: rtl/rc_permutation_core.sv
// rcPermutation: iterative permutation core. Each round rotates the element order
// and adds (round+1) to every limb; done is a level held until reset.
module rcPermutation #(
    parameter int N_BITS     = 254,
    parameter int STATE_SIZE = 3,
    parameter int N_LIMBS    = 13,
    parameter int ROUNDS     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_BITS-1:0] inState  [STATE_SIZE][N_LIMBS],
    output logic [N_BITS-1:0] outState [STATE_SIZE][N_LIMBS],
    output logic              done
);

    localparam int RND_W = $clog2(ROUNDS + 1);

    logic [RND_W-1:0]  rnd;
    logic [N_BITS-1:0] st [STATE_SIZE][N_LIMBS];

    // Round 0 reads straight from inState, later rounds from the working state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rnd  <= '0;
            done <= 1'b0;
        end else if (enable && !done) begin
            for (int e = 0; e < STATE_SIZE; e++) begin
                for (int l = 0; l < N_LIMBS; l++) begin
                    st[e][l] <= ((rnd == '0) ? inState[(e + 1) % STATE_SIZE][l]
                                             : st[(e + 1) % STATE_SIZE][l])
                                + N_BITS'(rnd) + N_BITS'(1);
                end
            end
            rnd <= rnd + RND_W'(1);
            if (rnd == RND_W'(ROUNDS - 1)) begin
                done <= 1'b1;
            end
        end
    end

    assign outState = st;

endmodule

// File: rtl/rc_permutation_lanes_slot.sv
// rc_lane_slot: one lane's input register plus reset/enable gating around a
// single rcPermutation instance.
module rc_lane_slot
    import rc_lanes_pkg::*;
#(
    parameter int LANE       = 0,
    parameter int N_BITS     = DEF_N_BITS,
    parameter int STATE_SIZE = DEF_STATE_SIZE,
    parameter int N_LIMBS    = DEF_N_LIMBS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic [LANE_IDX_W-1:0] nLanes,
    input  logic                  loadEn,
    input  logic [N_BITS-1:0]     inState  [STATE_SIZE][N_LIMBS],
    output logic [N_BITS-1:0]     outState [STATE_SIZE][N_LIMBS],
    output logic                  done,
    output logic                  laneEnable
);

    logic [N_BITS-1:0] inReg [STATE_SIZE][N_LIMBS];
    logic              laneUsed;
    logic              laneRst;

    // The core only ever sees inReg, which is frozen between load and drain.
    always_ff @(posedge clk) begin
        if (loadEn) begin
            inReg <= inState;
        end
    end

    assign laneUsed   = LANE_IDX_W'(LANE) < nLanes;
    assign laneRst    = reset | ~active | ~laneUsed;
    assign laneEnable = active & laneUsed;

    rcPermutation #(
        .N_BITS     (N_BITS),
        .STATE_SIZE (STATE_SIZE),
        .N_LIMBS    (N_LIMBS)
    ) u_perm (
        .clk      (clk),
        .reset    (laneRst),
        .enable   (laneEnable),
        .inState  (inReg),
        .outState (outState),
        .done     (done)
    );

endmodule

// File: rtl/rc_permutation_lanes.sv
// rc_permutation_lanes: loads up to NUM_LANES states, permutes them concurrently,
// streams results back in load order. RC_LANES_CYCLE_COUNT_EN adds run_cycles.
module rc_permutation_lanes
    import rc_lanes_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int STATE_SIZE = DEF_STATE_SIZE,
    parameter int N_LIMBS    = DEF_N_LIMBS,
    parameter int N_BITS     = DEF_N_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in_state  [STATE_SIZE][N_LIMBS],
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_state [STATE_SIZE][N_LIMBS],
    output logic              out_last,
    output logic              busy,
`ifdef RC_LANES_CYCLE_COUNT_EN
    output logic [31:0]       run_cycles,
`endif
    output dbg_t              dbg
);

    // Handshake: a beat transfers on a rising clk edge where valid and ready are both
    // high; valid never waits on ready, and payload holds while valid is unanswered.
    fsm_t                  state;
    fsm_t                  stateNext;
    logic [LANE_IDX_W-1:0] loadCnt;
    logic [LANE_IDX_W-1:0] drainIdx;
    logic [LANE_IDX_W-1:0] nLanes;
    logic                  accept;
    logic                  closeBatch;
    logic                  laneActive;
    logic                  allDone;
    logic                  drainLast;
    logic [NUM_LANES-1:0]  loadEn;
    logic [NUM_LANES-1:0]  laneDone;
    logic [NUM_LANES-1:0]  laneEn;
    logic [N_BITS-1:0]     laneOut [NUM_LANES][STATE_SIZE][N_LIMBS];

    assign in_ready   = ~reset & ((state == IDLE) | (state == FILL));
    assign accept     = in_valid & in_ready;
    assign closeBatch = accept & (in_last | (loadCnt == LANE_IDX_W'(NUM_LANES - 1)));
    assign laneActive = (state == RUN) | (state == DRAIN);
    assign drainLast  = drainIdx == (nLanes - LANE_IDX_W'(1));
    assign out_valid  = state == DRAIN;
    assign out_last   = (state == DRAIN) & drainLast;
    assign busy       = state != IDLE;

    always_comb begin
        allDone = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            loadEn[i] = accept & (loadCnt == LANE_IDX_W'(i));
            if ((LANE_IDX_W'(i) < nLanes) && !laneDone[i]) begin
                allDone = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rc_lane_slot #(
            .LANE       (i),
            .N_BITS     (N_BITS),
            .STATE_SIZE (STATE_SIZE),
            .N_LIMBS    (N_LIMBS)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .active     (laneActive),
            .nLanes     (nLanes),
            .loadEn     (loadEn[i]),
            .inState    (in_state),
            .outState   (laneOut[i]),
            .done       (laneDone[i]),
            .laneEnable (laneEn[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, FILL: begin
                if (closeBatch) begin
                    stateNext = RUN;
                end else if (accept) begin
                    stateNext = FILL;
                end
            end
            RUN: begin
                if (allDone) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready && drainLast) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            loadCnt  <= '0;
            drainIdx <= '0;
            nLanes   <= '0;
        end else begin
            if (accept) begin
                loadCnt <= loadCnt + LANE_IDX_W'(1);
            end
            if (closeBatch) begin
                nLanes <= loadCnt + LANE_IDX_W'(1);
            end
            if ((state == DRAIN) && out_ready) begin
                if (drainLast) begin
                    loadCnt  <= '0;
                    drainIdx <= '0;
                    nLanes   <= '0;
                end else begin
                    drainIdx <= drainIdx + LANE_IDX_W'(1);
                end
            end
        end
    end

    // Output is forced to zero outside DRAIN so idle cycles never leak stale lane data.
    always_comb begin
        for (int e = 0; e < STATE_SIZE; e++) begin
            for (int l = 0; l < N_LIMBS; l++) begin
                out_state[e][l] = '0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if ((state == DRAIN) && (drainIdx == LANE_IDX_W'(i))) begin
                        out_state[e][l] = laneOut[i][e][l];
                    end
                end
            end
        end
    end

`ifdef RC_LANES_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cycles <= '0;
        end else if ((state != RUN) && (stateNext == RUN)) begin
            run_cycles <= '0;
        end else if ((state == RUN) && (run_cycles != 32'hFFFF_FFFF)) begin
            run_cycles <= run_cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        dbg          = '0;
        dbg.state    = state;
        dbg.loadCnt  = loadCnt;
        dbg.drainIdx = drainIdx;
        dbg.nLanes   = nLanes;
        dbg.laneEn   = MAX_LANES'(laneEn);
    end

endmodule

// File: tb/tb_rc_permutation_lanes.sv
// Directed bench for rc_permutation_lanes with four lanes; results are checked
// against a closed-form model of the five-round lane permutation.
module tb_rc_permutation_lanes;
    import rc_lanes_pkg::*;

    localparam int NL     = 4;
    localparam int NB     = DEF_N_BITS;
    localparam int SS     = DEF_STATE_SIZE;
    localparam int LL     = DEF_N_LIMBS;
    localparam int ROUNDS = 5;
    localparam int W      = NB * SS * LL;

    logic      clk;
    logic      reset;
    logic      in_valid;
    logic      in_ready;
    rc_state_t inState;
    logic      in_last;
    logic      out_valid;
    logic      out_ready;
    rc_state_t outState;
    logic      out_last;
    logic      busy;
    dbg_t      dbg;
`ifdef RC_LANES_CYCLE_COUNT_EN
    logic [31:0] run_cycles;
`endif

    logic [W:0] exp_q[$];
    int         vectors;
    int         miscompares;

    rc_permutation_lanes #(
        .NUM_LANES (NL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (inState),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (outState),
        .out_last  (out_last),
        .busy      (busy),
`ifdef RC_LANES_CYCLE_COUNT_EN
        .run_cycles(run_cycles),
`endif
        .dbg       (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] flatten(input rc_state_t s);
        logic [W-1:0] f;
        f = '0;
        for (int e = 0; e < SS; e++)
            for (int l = 0; l < LL; l++)
                f[(e * LL + l) * NB +: NB] = s[e][l];
        return f;
    endfunction

    // Five rounds of (rotate by one, add round+1): element e ends up holding
    // input element (e+5)%3 plus 1+2+3+4+5 = 15.
    function automatic logic [W-1:0] golden(input rc_state_t s);
        logic [W-1:0] f;
        logic [NB-1:0] v;
        f = '0;
        for (int e = 0; e < SS; e++)
            for (int l = 0; l < LL; l++) begin
                v = s[(e + ROUNDS) % SS][l] + NB'(15);
                f[(e * LL + l) * NB +: NB] = v;
            end
        return f;
    endfunction

    task automatic randState(output rc_state_t s);
        logic [255:0] t;
        for (int e = 0; e < SS; e++)
            for (int l = 0; l < LL; l++) begin
                for (int c = 0; c < 8; c++) t[c * 32 +: 32] = $urandom();
                s[e][l] = t[NB-1:0];
            end
    endtask

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkData(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], expv[63:0]);
        end
    endtask

    task automatic armBeat(input logic last, input logic closes);
        rc_state_t s;
        randState(s);
        inState  = s;
        in_valid = 1'b1;
        in_last  = last;
        exp_q.push_back({closes, golden(s)});
    endtask

    task automatic sendBeat(input logic last, input logic closes);
        int waitCnt;
        armBeat(last, closes);
        waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 50) checkVal("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the closing beat's handshake edge.
    task automatic drainBatch(input int n, input int stall, input string tag);
        int         waitCnt;
        bit         sawReady;
        bit         sawUpper;
        logic [W:0] e;
        waitCnt  = 0;
        sawReady = 1'b0;
        sawUpper = 1'b0;
        @(negedge clk);
        while (!out_valid && waitCnt < 200) begin
            if (in_ready) sawReady = 1'b1;
            for (int i = n; i < NL; i++) if (dbg.laneEn[i]) sawUpper = 1'b1;
            @(negedge clk);
            waitCnt++;
        end
        checkVal({tag, "_latency"}, 64'(waitCnt + 1), 64'(ROUNDS + 2));
        if (waitCnt >= 200) return;
        checkVal({tag, "_ready_in_run"}, 64'(sawReady), 64'd0);
        checkVal({tag, "_unused_lanes"}, 64'(sawUpper), 64'd0);
`ifdef RC_LANES_CYCLE_COUNT_EN
        checkVal({tag, "_run_cycles"}, 64'(run_cycles), 64'(waitCnt));
`endif
        for (int k = 0; k < n; k++) begin
            checkVal({tag, "_out_valid"}, 64'(out_valid), 64'd1);
            checkVal({tag, "_ready_in_drain"}, 64'(in_ready), 64'd0);
            if (exp_q.size() == 0) begin
                checkVal({tag, "_queue_empty"}, 64'd0, 64'd1);
                e = '0;
            end else begin
                e = exp_q.pop_front();
            end
            checkData({tag, "_data"}, flatten(outState), e[W-1:0]);
            checkVal({tag, "_out_last"}, 64'(out_last), 64'(e[W]));
            checkVal({tag, "_drain_idx"}, 64'(dbg.drainIdx), 64'(k));
            if (k == 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    checkVal({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
                    checkData({tag, "_stall_data"}, flatten(outState), e[W-1:0]);
                    checkVal({tag, "_stall_idx"}, 64'(dbg.drainIdx), 64'd0);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checkVal({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        checkVal({tag, "_post_ready"}, 64'(in_ready), 64'd1);
        checkVal({tag, "_post_busy"}, 64'(busy), 64'd0);
        checkData({tag, "_post_zero"}, flatten(outState), '0);
    endtask

    initial begin
        bit sawValid;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        for (int e = 0; e < SS; e++)
            for (int l = 0; l < LL; l++) inState[e][l] = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst_in_ready", 64'(in_ready), 64'd0);
        checkVal("rst_out_valid", 64'(out_valid), 64'd0);
        checkVal("rst_out_last", 64'(out_last), 64'd0);
        checkVal("rst_busy", 64'(busy), 64'd0);
        checkVal("rst_state", 64'(dbg.state), 64'(IDLE));
        checkVal("rst_counters", 64'({dbg.loadCnt, dbg.drainIdx, dbg.nLanes}), 64'd0);
        checkData("rst_out_state", flatten(outState), '0);
`ifdef RC_LANES_CYCLE_COUNT_EN
        checkVal("rst_run_cycles", 64'(run_cycles), 64'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkVal("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Two-beat partial batch
        sendBeat(1'b0, 1'b0);
        sendBeat(1'b1, 1'b1);
        drainBatch(2, 0, "two_beat");

        // Single-beat batch: lanes 1..3 never enabled
        @(posedge clk);
        #1;
        sendBeat(1'b1, 1'b1);
        drainBatch(1, 0, "one_beat");

        // Full batch closes on beat 4 without in_last; fifth beat waits for IDLE
        @(posedge clk);
        #1;
        for (int b = 0; b < NL - 1; b++) sendBeat(1'b0, 1'b0);
        sendBeat(1'b0, 1'b1);
        armBeat(1'b1, 1'b1);
        drainBatch(NL, 0, "full");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        drainBatch(1, 0, "fifth");

        // Backpressure: 20 stalled cycles on the first result
        @(posedge clk);
        #1;
        sendBeat(1'b0, 1'b0);
        sendBeat(1'b0, 1'b0);
        sendBeat(1'b1, 1'b1);
        drainBatch(3, 20, "stall");

        // Reset in the middle of RUN
        @(posedge clk);
        #1;
        sendBeat(1'b0, 1'b0);
        sendBeat(1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkVal("pre_abort_state", 64'(dbg.state), 64'(RUN));
        reset = 1'b1;
        @(negedge clk);
        checkVal("abort_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkVal("abort_busy", 64'(busy), 64'd0);
        checkVal("abort_out_valid", 64'(out_valid), 64'd0);
        checkVal("abort_in_ready", 64'(in_ready), 64'd1);
        checkData("abort_out_state", flatten(outState), '0);
`ifdef RC_LANES_CYCLE_COUNT_EN
        checkVal("abort_run_cycles", 64'(run_cycles), 64'd0);
`endif
        sawValid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkVal("abort_no_output", 64'(sawValid), 64'd0);
        @(posedge clk);
        #1;
        sendBeat(1'b1, 1'b1);
        drainBatch(1, 0, "after_abort");

        checkVal("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
